// File: rtl/dac_burst_seq_pkg.sv
// Shared definitions for the DAC burst playback sequencer.
package dac_burst_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_PLAY  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   // A repetition count of this value means play until aborted.
   localparam int unsigned REP_CONT = 0;

endpackage

// File: rtl/dac_burst_cnt.sv
// Loadable down-counter with zero flag; stops at zero.
module dac_burst_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         i_clk,
   input  logic         i_clr,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] cnt_q;

   // Load has priority over decrement; decrement saturates at zero.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         cnt_q <= '0;
      end else if (i_load) begin
         cnt_q <= i_val;
      end else if (i_dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/dac_burst_seq.sv
// DAC burst sequencer: trigger, programmed delay, then repeated RAM
// address sweeps with an optional idle gap between repetitions.
module dac_burst_seq
   import dac_burst_seq_pkg::*;
#(
   parameter int unsigned AW = 13,
   parameter int unsigned RW = 16,
   parameter int unsigned GW = 16
) (
   input  logic          i_clk,
   input  logic          i_clr,
   input  logic          i_start,
   input  logic          i_abort,
   input  logic [31:0]   i_delay,
   input  logic [AW-1:0] i_len,
   input  logic [RW-1:0] i_reps,
   input  logic [GW-1:0] i_gap,
   output logic [AW-1:0] o_ram_addr,
   output logic          o_play,
   output logic          o_busy,
   output logic          o_done,
   output logic [RW-1:0] o_rep_cnt
);

   state_t        state_q, state_d;
   logic [AW-1:0] len_s, addr_d;
   logic [RW-1:0] reps_s, rep_d, rep_inc;
   logic [GW-1:0] gap_s;
   logic          play_d, busy_d, done_d;
   logic          start_ok;
   logic          dly_load, dly_dec, dly_zero;
   logic          gap_load, gap_dec, gap_zero;

   assign start_ok = (state_q == ST_IDLE) && i_start && !i_abort;
   assign rep_inc  = o_rep_cnt + 1'b1;

   dac_burst_cnt #(.W(32)) u_dly_cnt (
      .i_clk  (i_clk),
      .i_clr  (i_clr),
      .i_load (dly_load),
      .i_val  (i_delay),
      .i_dec  (dly_dec),
      .o_zero (dly_zero)
   );

   // Gap counter is loaded with gap-1 so the GAP state lasts exactly gap clocks.
   dac_burst_cnt #(.W(GW)) u_gap_cnt (
      .i_clk  (i_clk),
      .i_clr  (i_clr),
      .i_load (gap_load),
      .i_val  (gap_s - 1'b1),
      .i_dec  (gap_dec),
      .o_zero (gap_zero)
   );

   // Shadow copies of the burst configuration, frozen at start.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         len_s  <= '0;
         reps_s <= '0;
         gap_s  <= '0;
      end else if (start_ok) begin
         len_s  <= i_len;
         reps_s <= i_reps;
         gap_s  <= i_gap;
      end
   end

   // State and all outputs are registered.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         state_q    <= ST_IDLE;
         o_ram_addr <= '0;
         o_play     <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_rep_cnt  <= '0;
      end else begin
         state_q    <= state_d;
         o_ram_addr <= addr_d;
         o_play     <= play_d;
         o_busy     <= busy_d;
         o_done     <= done_d;
         o_rep_cnt  <= rep_d;
      end
   end

   // Next-state and next-output logic; abort overrides every transition.
   always_comb begin
      state_d  = state_q;
      addr_d   = o_ram_addr;
      play_d   = o_play;
      busy_d   = o_busy;
      done_d   = 1'b0;
      rep_d    = o_rep_cnt;
      dly_load = 1'b0;
      dly_dec  = 1'b0;
      gap_load = 1'b0;
      gap_dec  = 1'b0;

      if ((state_q != ST_IDLE) && i_abort) begin
         state_d = ST_IDLE;
         addr_d  = '0;
         play_d  = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_ok) begin
                  state_d  = ST_DELAY;
                  busy_d   = 1'b1;
                  rep_d    = '0;
                  dly_load = 1'b1;
               end
            end
            ST_DELAY: begin
               if (dly_zero) begin
                  state_d = ST_PLAY;
                  addr_d  = '0;
                  play_d  = 1'b1;
               end else begin
                  dly_dec = 1'b1;
               end
            end
            ST_PLAY: begin
               if (o_ram_addr == len_s) begin
                  rep_d = rep_inc;
                  if ((reps_s != RW'(REP_CONT)) && (rep_inc == reps_s)) begin
                     state_d = ST_IDLE;
                     play_d  = 1'b0;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else if (gap_s == '0) begin
                     addr_d = '0;
                  end else begin
                     state_d  = ST_GAP;
                     gap_load = 1'b1;
                     play_d   = 1'b0;
                  end
               end else begin
                  addr_d = o_ram_addr + 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_zero) begin
                  state_d = ST_PLAY;
                  addr_d  = '0;
                  play_d  = 1'b1;
               end else begin
                  gap_dec = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/dac_burst_seq.md
Name: dac_burst_seq

Overview:
- Sequencer for the DAC waveform playback path.
- On a trigger it waits a programmed delay, then generates RAM read addresses for a programmed number of waveform repetitions, with an optional idle gap between repetitions.
- Sits between the DAC register block (config, len, delay, trigger) and the dual-port waveform RAM read port (port B, DAC clock domain).
- Replaces free-running address counting with a deterministic, abortable burst.

Parameters:
- AW, 13, RAM read-address width; the last-sample index also uses this width.
- RW, 16, repetition-count width.
- GW, 16, inter-repetition gap-count width.

Ports:
- i_clk  in  1  DAC sample clock.
- i_clr  in  1  synchronous active-high reset.
- i_start  in  1  trigger pulse (already debounced and edge-detected upstream); sampled only in IDLE.
- i_abort  in  1  level; forces return to IDLE.
- i_delay  in  32  trigger-to-first-sample delay, in clocks.
- i_len  in  AW  index of the last sample (inclusive); waveform length is i_len+1.
- i_reps  in  RW  repetition count; 0 means continuous until abort.
- i_gap  in  GW  idle clocks between repetitions.
- o_ram_addr  out  AW  RAM port-B read address (registered).
- o_play  out  1  high while o_ram_addr is valid playback.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-clock pulse on normal burst completion.
- o_rep_cnt  out  RW  number of repetitions completed in the current or last burst.

Behaviour:
- Reset (i_clr=1 at a rising edge) takes effect on that edge, regardless of state:
  - state=IDLE;
  - o_ram_addr=0, o_play=0, o_busy=0, o_done=0, o_rep_cnt=0;
  - internal counters cleared.
- States: IDLE, DELAY, PLAY, GAP.
- IDLE:
  - i_start=1 at edge t: latch i_delay, i_len, i_reps, i_gap into shadow registers; clear o_rep_cnt; go to DELAY with dly_cnt=i_delay.
  - o_busy=1 from t+1.
- DELAY:
  - dly_cnt!=0: decrement.
  - dly_cnt==0: go to PLAY with o_ram_addr=0, o_play=1.
  - The first PLAY cycle is t+2+delay (delay=0 gives first sample at t+2).
- PLAY:
  - o_play=1; o_ram_addr increments by 1 per clock.
  - When o_ram_addr==len_s, that sample is the last of the repetition. On the following edge, o_rep_cnt += 1, then:
    - reps_s!=0 and o_rep_cnt+1==reps_s: go to IDLE; o_play=0, o_busy=0; o_done=1 for exactly that one cycle.
    - else gap_s==0: o_ram_addr=0 and stay in PLAY, with no bubble.
    - else: go to GAP with gap_cnt=gap_s-1, o_play=0, o_ram_addr holds.
  - len_s=0 gives single-sample repetitions, one per clock (when gap=0).
- GAP:
  - gap_cnt!=0: decrement.
  - gap_cnt==0: go to PLAY with o_ram_addr=0.
  - The number of GAP cycles equals gap_s exactly.
- Continuous mode (reps_s=0): the repetition count never terminates the burst. o_rep_cnt wraps modulo 2^RW.
- i_abort=1 in any non-IDLE state:
  - next state IDLE; o_play=0, o_busy=0, o_ram_addr=0;
  - o_done is NOT pulsed; o_rep_cnt holds.
  - Abort has priority over every state transition, including completion in the same cycle.
- i_abort=1 in IDLE blocks i_start (start ignored while abort is asserted).
- i_start while busy is ignored; no retrigger.
- Changes to i_delay, i_len, i_reps or i_gap during a burst have no effect until the next start.
- Priority order: i_clr > i_abort > state logic.
- No combinational path from inputs to outputs. All outputs are registered.

Decomposition:
- Shared DAC defines/package holds:
  - state encodings ST_IDLE=2'd0, ST_DELAY=2'd1, ST_PLAY=2'd2, ST_GAP=2'd3;
  - the REP_CONT=0 continuous-mode code.
- One sub-module is natural: dac_burst_cnt, a loadable down-counter with zero flag, instantiated for delay (32 b) and gap (GW). The address/repetition logic stays in the top module.

Test Plan:
1. Reset: i_clr held 3 clocks mid-PLAY -> next edge o_busy=0, o_play=0, o_ram_addr=0, o_rep_cnt=0; no o_done.
2. Basic burst: delay=3, len=4, reps=2, gap=0, start at t -> addresses 0,1,2,3,4,0,1,2,3,4 on cycles t+5..t+14; o_done=1 on t+15 only; o_rep_cnt=2.
3. Gap and zero delay: delay=0, len=1, reps=3, gap=2 -> pattern 0,1,gap,gap,0,1,gap,gap,0,1 starting at t+2; o_play low exactly in the 2-cycle gaps; one o_done.
4. Continuous plus abort: reps=0, len=2, gap=0; run 10 repetitions -> o_rep_cnt=10; assert i_abort -> IDLE next edge, no o_done, o_rep_cnt stays 10.
5. Ignored inputs: i_start pulses during DELAY/PLAY, and i_len changed to 7 mid-burst -> addresses still wrap at the original len. i_start with i_abort=1 in IDLE -> stays IDLE.
6. Edge case: len=0, reps=1, delay=0 -> a single o_play cycle with addr 0 at t+2; o_done at t+3. Also abort coinciding with the final sample -> no o_done.
